// File: rtl/noc_mem_packet_adaptor.sv
// noc_mem_packet_adaptor: bridges request packets from the router's local port
// onto a single-port 1024x32 memory with 1-cycle read latency. Write packets
// become byte-enabled write bursts; read packets return a response packet.
//
// Handshakes: a flit moves on in_* when in_valid & in_ready, and on out_* when
// out_valid & out_ready, both sampled at the rising clock edge. A producer that
// raises valid keeps data stable until the transfer; out_data is held while
// out_valid & ~out_ready.
module noc_mem_packet_adaptor #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              busy,
  output logic              err_cmd,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WRITE   = 2'd1,
    S_RSP_HDR = 2'd2,
    S_READ    = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [8:0]          r_rem;
  logic [7:0]          r_len_m1;
  logic [3:0]          r_be;
  logic [7:0]          r_src;
  logic                r_inflight;
  logic [DATA_W-1:0]   r_fifo [0:1];
  logic                r_wr_ptr;
  logic                r_rd_ptr;
  logic [1:0]          r_count;

  logic [1:0]          w_cmd;
  logic                w_hdr_ok;
  logic                w_wr_beat;
  logic                w_rd_valid;
  logic                w_pop;
  logic                w_fifo_pop;
  logic                w_push;
  logic [2:0]          w_outstanding;
  logic [2:0]          w_after;
  logic                w_issue;
  logic [DATA_W-1:0]   w_fifo_head;

  assign w_cmd     = in_data[31:30];
  assign w_hdr_ok  = (r_state == S_IDLE) && in_valid &&
                     ((w_cmd == 2'b01) || (w_cmd == 2'b10));
  assign w_wr_beat = (r_state == S_WRITE) && in_valid;

  // Response data path: when the FIFO is empty the memory output is forwarded
  // straight through, so the first data flit costs no extra cycle.
  assign w_rd_valid    = (r_count != 2'd0) || r_inflight;
  assign w_fifo_head   = (r_count == 2'd0) ? mem_readdata : r_fifo[r_rd_ptr];
  assign w_pop         = (r_state == S_READ) && w_rd_valid && out_ready;
  assign w_fifo_pop    = w_pop && (r_count != 2'd0);
  assign w_push        = r_inflight && !(w_pop && (r_count == 2'd0));
  assign w_outstanding = {1'b0, r_count} + {2'b00, r_inflight};
  assign w_after       = w_outstanding - {2'b00, w_pop};
  assign w_issue       = (r_state == S_READ) && (r_rem != 9'd0) && (w_after < 3'd2);

  assign mem_writedata = in_data;
  assign mem_clken     = 1'b1;
  assign busy          = !reset && (r_state != S_IDLE);
  assign dbg_state     = r_state;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state and all handshake / memory strobes; everything idles in reset.
  always_comb begin
    w_state_next   = r_state;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    out_data       = w_fifo_head;
    mem_address    = '0;
    mem_byteenable = 4'hF;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    err_cmd        = 1'b0;
    if (!reset) begin
      mem_address = r_addr;
      case (r_state)
        S_IDLE: begin
          in_ready = 1'b1;
          if (in_valid) begin
            case (w_cmd)
              2'b01:   w_state_next = S_WRITE;
              2'b10:   w_state_next = S_RSP_HDR;
              default: err_cmd = 1'b1;
            endcase
          end
        end
        S_WRITE: begin
          in_ready = 1'b1;
          if (in_valid) begin
            mem_chipselect = 1'b1;
            mem_write      = 1'b1;
            mem_byteenable = r_be;
            if (r_rem == 9'd1) w_state_next = S_IDLE;
          end
        end
        S_RSP_HDR: begin
          out_valid = 1'b1;
          out_data  = {2'b11, r_addr, r_len_m1, 4'hF, r_src};
          if (out_ready) w_state_next = S_READ;
        end
        S_READ: begin
          out_valid      = w_rd_valid;
          mem_chipselect = w_issue;
          if ((r_rem == 9'd0) && (w_after == 3'd0)) w_state_next = S_IDLE;
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Packet context: latched from a legal header, advanced per memory access.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr   <= '0;
      r_rem    <= 9'd0;
      r_len_m1 <= 8'd0;
      r_be     <= 4'd0;
      r_src    <= 8'd0;
    end else if (w_hdr_ok) begin
      r_addr   <= in_data[20 +: ADDR_W];
      r_rem    <= {1'b0, in_data[19:12]} + 9'd1;
      r_len_m1 <= in_data[19:12];
      r_be     <= in_data[11:8];
      r_src    <= in_data[7:0];
    end else if (w_wr_beat || w_issue) begin
      r_addr   <= r_addr + 1'b1;
      r_rem    <= r_rem - 9'd1;
    end
  end

  // Read pipeline: one-cycle inflight flag plus a 2-entry response FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inflight <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      r_inflight <= w_issue;
      if (w_push) begin
        r_fifo[r_wr_ptr] <= mem_readdata;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_fifo_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_fifo_pop};
    end
  end

endmodule
